// File: rtl/packet_forwarder.sv
// Purpose: streams a stored packet out of packet_ram (addresses 0..last_addr) as a valid/ready stream with tlast, then pulses fwd_done.
// Latency: start in cycle 0 -> first read in cycle 1 -> first beat valid in cycle 3; sustains 1 beat/cycle with m_tready held high.
// Backpressure: a read is issued only if buffered + in-flight words stay below 2, so a stalled sink never drops or overwrites data.
module packet_forwarder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  fwd_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  // One bit wider than the RAM address so reading the top word cannot wrap the counter.
  logic [ADDR_WIDTH:0]   addr_cnt_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic                  rd_pend_q;
  logic                  rd_pend_last_q;
  logic [1:0]            buf_cnt_q;
  logic [DATA_WIDTH-1:0] head_dat_q, tail_dat_q;
  logic                  head_last_q, tail_last_q;
  logic                  pop;
  logic                  issue_last;
  logic [1:0]            occupancy;

  assign pop        = m_tvalid & m_tready;
  assign m_tvalid   = (buf_cnt_q != 2'd0);
  assign m_tdata    = head_dat_q;
  assign m_tlast    = m_tvalid & head_last_q;
  assign ram_addr   = addr_cnt_q[ADDR_WIDTH-1:0];
  // Words that will be held after this cycle, counting the read in flight but not a new one.
  assign occupancy  = buf_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  assign issue_last = ram_rd_en & (addr_cnt_q == {1'b0, last_addr_q});

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (issue_last) state_d = DRAIN;
      DRAIN:   if (pop && head_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and buffer occupancy
  always_comb begin
    ram_rd_en = (state_q == READ) && (occupancy < 2'd2);
    busy      = (state_q != IDLE);
    fwd_done  = (state_q == DONE);
  end

  // Address counter, read tracking and the 2-entry output buffer (head drives the stream)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_cnt_q     <= '0;
      last_addr_q    <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      buf_cnt_q      <= 2'd0;
      head_dat_q     <= '0;
      tail_dat_q     <= '0;
      head_last_q    <= 1'b0;
      tail_last_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        addr_cnt_q  <= '0;
        last_addr_q <= last_addr;
      end else if (ram_rd_en) begin
        addr_cnt_q  <= addr_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      rd_pend_q      <= ram_rd_en;
      rd_pend_last_q <= issue_last;
      case ({rd_pend_q, pop})
        2'b10: begin
          if (buf_cnt_q == 2'd0) begin
            head_dat_q  <= ram_rdata;
            head_last_q <= rd_pend_last_q;
          end else begin
            tail_dat_q  <= ram_rdata;
            tail_last_q <= rd_pend_last_q;
          end
          buf_cnt_q <= buf_cnt_q + 2'd1;
        end
        2'b01: begin
          head_dat_q  <= tail_dat_q;
          head_last_q <= tail_last_q;
          buf_cnt_q   <= buf_cnt_q - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_q == 2'd1) begin
            head_dat_q  <= ram_rdata;
            head_last_q <= rd_pend_last_q;
          end else begin
            head_dat_q  <= tail_dat_q;
            head_last_q <= tail_last_q;
            tail_dat_q  <= ram_rdata;
            tail_last_q <= rd_pend_last_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_forwarder.sv
// Purpose: random-data, random-backpressure bench for packet_forwarder with a queue-based reference model.
// Latency: expected beats are queued when a start is accepted; a negedge monitor pops and compares each handshake.
// Backpressure: m_tready is always-high, 50% or 25% random per packet; stalled beats must hold data/tlast.
module tb_packet_forwarder;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          busy;
  logic          fwd_done;

  always #5 clk = ~clk;

  packet_forwarder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_addr(last_addr),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .fwd_done(fwd_done)
  );

  // packet_ram model: registered read, data one cycle after the enable
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

  typedef struct packed { logic [DW-1:0] dat; logic last; } beat_t;
  beat_t sb_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state, each value describing the current cycle
  bit    exp_busy = 0, exp_done = 0;
  int    rd_left = 0, exp_addr = 0, outstanding = 0, beat_idx = 0, start_cyc = 0;
  bit    full_rate = 0;
  int    ready_mode = 0;
  bit    prev_stall = 0, chk_post_rst = 0;
  logic [DW-1:0] prev_dat;
  logic  prev_last;
  beat_t b;
  bit    last_hs, was_busy;

  // Monitor: compares DUT outputs mid-cycle, then advances the model to the next cycle
  always @(negedge clk) begin
    if (chk_post_rst) begin
      chk("post_rst_tvalid", m_tvalid, 0);
      chk("post_rst_rd_en", ram_rd_en, 0);
      chk_post_rst = 0;
    end
    chk("busy", busy, exp_busy);
    chk("fwd_done", fwd_done, exp_done);
    if (!rst_n) begin
      exp_busy = 0; exp_done = 0; rd_left = 0; exp_addr = 0; outstanding = 0;
      prev_stall = 0; chk_post_rst = 1;
      sb_q.delete();
    end else begin
      last_hs = 0;
      if (prev_stall) begin
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_tdata", m_tdata, prev_dat);
        chk("stall_tlast", m_tlast, prev_last);
      end
      if (exp_busy && cyc == start_cyc + 2) chk("tvalid_early", m_tvalid, 0);
      if (exp_busy && cyc == start_cyc + 3) chk("tvalid_latency", m_tvalid, 1);
      if (ram_rd_en) begin
        if (rd_left == 0) chk("rd_unexpected", ram_rd_en, 0);
        else begin
          chk("rd_addr", ram_addr, exp_addr);
          exp_addr++; rd_left--; outstanding++;
        end
      end
      if (m_tvalid && m_tready) begin
        outstanding--;
        if (sb_q.size() == 0) chk("extra_beat", m_tvalid, 0);
        else begin
          b = sb_q.pop_front();
          chk("tdata", m_tdata, b.dat);
          chk("tlast", m_tlast, b.last);
          if (full_rate) chk("beat_cycle", cyc, start_cyc + 3 + beat_idx);
          beat_idx++;
          last_hs = b.last;
        end
      end
      chk("outstanding_le2", (outstanding <= 2), 1);
      prev_stall = m_tvalid && !m_tready;
      prev_dat   = m_tdata;
      prev_last  = m_tlast;
      was_busy = exp_busy;
      if (exp_done) begin
        exp_done = 0; exp_busy = 0;
      end else if (last_hs) begin
        exp_done = 1;
      end
      if (!was_busy && start) begin
        exp_busy = 1; start_cyc = cyc; rd_left = int'(last_addr) + 1; exp_addr = 0;
        beat_idx = 0; outstanding = 0; full_rate = (ready_mode == 0);
        for (int i = 0; i <= int'(last_addr); i++) begin
          b.dat = mem[i]; b.last = (i == int'(last_addr));
          sb_q.push_back(b);
        end
      end
    end
  end

  // Sink backpressure pattern
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(0, 1) == 1);
      default: m_tready = ($urandom_range(0, 3) == 0);
    endcase
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while ((exp_busy || exp_done) && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 5000) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy=%0d, expected packet to complete", busy);
    end
  endtask

  task automatic start_pkt(input int last, input int mode);
    wait_idle();
    ready_mode = mode;
    for (int i = 0; i <= last; i++) mem[i] = $urandom;
    last_addr = last[AW-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    last_addr = AW'($urandom);
  endtask

  task automatic send_pkt(input int last, input int mode);
    start_pkt(last, mode);
    wait_idle();
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fwd_done", fwd_done, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_addr", ram_addr, 0);
    rst_n = 1'b1;

    send_pkt(3, 0);
    send_pkt(0, 0);
    send_pkt(7, 1);
    send_pkt(1023, 0);
    send_pkt(1023, 2);

    // Reset after two of five beats
    start_pkt(4, 0);
    n = 0;
    while (beat_idx < 2 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL beat_wait_timeout: beats=%0d, expected 2", beat_idx);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_pkt(5, 0);

    // Start pulses during READ and during DONE are ignored
    start_pkt(9, 0);
    repeat (2) begin @(posedge clk); #1; end
    last_addr = 2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!exp_done && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL done_wait_timeout: fwd_done=%0d, expected 1", fwd_done);
    end
    last_addr = 3; start = 1'b1;
    @(posedge clk); #1;
    last_addr = 2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    repeat (15) send_pkt($urandom_range(0, 40), $urandom_range(0, 2));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
